// File: rtl/classifier_pkg.sv
// Shared types and default sizes for the digit-classifier sequencer.
// The optional WAIT timeout is enabled by defining CLASSIFIER_TIMEOUT_EN.
package classifier_pkg;

  localparam int DEF_NUM_ROWS       = 10;
  localparam int DEF_RESULT_W       = 16;
  localparam int DEF_ROW_SEL_W      = 4;
  localparam int DEF_TIMEOUT_CYCLES = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  typedef logic signed [DEF_RESULT_W-1:0] score_t;

endpackage

// File: rtl/classifier_sequencer_argmax_tracker.sv
// Running signed maximum and its row index; ties keep the earliest row
// because only a strictly greater score replaces the current best.
module argmax_tracker import classifier_pkg::*; #(
  parameter int RESULT_W = DEF_RESULT_W,
  parameter int IDX_W    = DEF_ROW_SEL_W
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_clear,
  input  logic                       i_load_valid,
  input  logic [IDX_W-1:0]           i_idx,
  input  logic signed [RESULT_W-1:0] i_score,
  output logic [IDX_W-1:0]           o_best_idx,
  output logic signed [RESULT_W-1:0] o_best_score
);

  logic [IDX_W-1:0]           r_best_idx;
  logic signed [RESULT_W-1:0] r_best_score;
  logic                       w_take;

  // Row 0 always seeds the tracker so stale contents never win.
  assign w_take = i_load_valid && ((i_idx == '0) || (i_score > r_best_score));

  always_ff @(posedge clk) begin
    if (!n_rst || i_clear) begin
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else if (w_take) begin
      r_best_idx   <= i_idx;
      r_best_score <= i_score;
    end
  end

  assign o_best_idx   = r_best_idx;
  assign o_best_score = r_best_score;

endmodule

// File: rtl/classifier_sequencer.sv
// Steps the multiplier through every output row and reports the argmax row.
// Define CLASSIFIER_TIMEOUT_EN to bound each WAIT and flag a stalled multiplier.
module classifier_sequencer import classifier_pkg::*; #(
  parameter int NUM_ROWS       = DEF_NUM_ROWS,
  parameter int RESULT_W       = DEF_RESULT_W,
  parameter int ROW_SEL_W      = DEF_ROW_SEL_W
`ifdef CLASSIFIER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_start_classify,
  input  logic                 i_done_row,
  input  logic [RESULT_W-1:0]  i_row_result,
  output logic [ROW_SEL_W-1:0] o_row_select,
  output logic                 o_begin_mult,
  output logic                 o_busy,
  output logic                 o_classify_done,
  output logic [ROW_SEL_W-1:0] o_digit,
  output logic [RESULT_W-1:0]  o_max_score,
  output logic                 o_timeout_err
);

  localparam logic [ROW_SEL_W-1:0] ROW_ONE  = ROW_SEL_W'(1);
  localparam logic [ROW_SEL_W-1:0] ROW_LAST = ROW_SEL_W'(NUM_ROWS - 1);

  state_t                     r_state;
  state_t                     w_next;
  logic [ROW_SEL_W-1:0]       r_row;
  logic                       r_done_d;
  logic signed [RESULT_W-1:0] r_cur;
  logic [ROW_SEL_W-1:0]       r_digit;
  logic [RESULT_W-1:0]        r_max_score;
  logic                       w_start;
  logic                       w_edge;
  logic                       w_last;
  logic                       w_timeout;
  logic [ROW_SEL_W-1:0]       w_best_idx;
  logic signed [RESULT_W-1:0] w_best_score;

  assign w_start = (r_state == S_IDLE) && i_start_classify;
  // Only a fresh rising edge counts, so a held or stale done_row is ignored.
  assign w_edge  = i_done_row & ~r_done_d;
  assign w_last  = (r_row == ROW_LAST);

`ifdef CLASSIFIER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_timeout_err;

  assign w_timeout = (r_state == S_WAIT) && !w_edge && (r_wait_cnt == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + TO_ONE;
      if (w_start)        r_timeout_err <= 1'b0;
      else if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start_classify) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT: begin
        if (w_edge)         w_next = S_COMPARE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_COMPARE: w_next = w_last ? S_DONE : S_ISSUE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_done_d    <= 1'b0;
      r_cur       <= '0;
      r_digit     <= '0;
      r_max_score <= '0;
    end else begin
      r_state  <= w_next;
      r_done_d <= i_done_row;
      if (w_start)                              r_row <= '0;
      else if (r_state == S_COMPARE && !w_last) r_row <= r_row + ROW_ONE;
      if (r_state == S_WAIT && w_edge) r_cur <= i_row_result;
      if (r_state == S_DONE) begin
        r_digit     <= w_best_idx;
        r_max_score <= w_best_score;
      end
    end
  end

  argmax_tracker #(
    .RESULT_W (RESULT_W),
    .IDX_W    (ROW_SEL_W)
  ) u_argmax (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_clear      (w_start),
    .i_load_valid (r_state == S_COMPARE),
    .i_idx        (r_row),
    .i_score      (r_cur),
    .o_best_idx   (w_best_idx),
    .o_best_score (w_best_score)
  );

  assign o_row_select    = r_row;
  assign o_begin_mult    = (r_state == S_ISSUE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_classify_done = (r_state == S_DONE);
  assign o_digit         = r_digit;
  assign o_max_score     = r_max_score;

endmodule
